// File: rtl/mem_access_unit.sv
// Memory access unit: turns the one-hot memory-control field into a single
// req/ack RAM transaction (fetch at PC, read/write at AR), with a timeout and sticky error flags.
module mem_access_unit #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        mem_ctrl,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] ar_in,
  input  logic [DATA_W-1:0] dr_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_req,
  output logic              ram_we,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [5:0]        mbru,
  output logic [DATA_W-1:0] ir_data,
  output logic [DATA_W-1:0] dr_out,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_timeout,
  output logic              err_overrun
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  typedef enum logic [1:0] {CMD_FETCH, CMD_READ, CMD_WRITE} cmd_t;

  state_t            state_q, state_d;
  cmd_t              cmd_q;
  logic [2:0]        prev_ctrl;
  logic [CNT_W-1:0]  tcnt;

  logic              cmd_edge;
  logic              one_hot;
  logic              accept;
  logic              illegal;
  logic              overrun;
  logic              ack_ok;
  logic              tmo;
  logic [DATA_W-1:0] cap_data;

  // A command is the rising edge of a nonzero field, so a held value issues once.
  assign cmd_edge = (mem_ctrl != 3'b000) && (prev_ctrl == 3'b000);
  assign one_hot  = ((mem_ctrl & (mem_ctrl - 3'd1)) == 3'b000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    illegal = 1'b0;
    ack_ok  = 1'b0;
    tmo     = 1'b0;
    overrun = cmd_edge && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (cmd_edge) begin
          if (one_hot) begin
            accept  = 1'b1;
            state_d = REQ;
          end else begin
            illegal = 1'b1;
          end
        end
      end
      REQ: begin
        // An ack coinciding with the final timeout count still wins.
        if (ram_ack) begin
          ack_ok  = 1'b1;
          state_d = DONE;
        end else if (tcnt == CNT_W'(TIMEOUT)) begin
          tmo     = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // On timeout the destination is zeroed; mbru = 0 sends the control unit back to FETCH1.
  assign cap_data = ack_ok ? ram_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_ctrl   <= 3'b000;
      cmd_q       <= CMD_FETCH;
      tcnt        <= '0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_req     <= 1'b0;
      ram_we      <= 1'b0;
      mbru        <= '0;
      ir_data     <= '0;
      dr_out      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      prev_ctrl <= mem_ctrl;
      done      <= ack_ok | tmo;

      if (accept) begin
        if (mem_ctrl[2])      cmd_q <= CMD_FETCH;
        else if (mem_ctrl[1]) cmd_q <= CMD_READ;
        else                  cmd_q <= CMD_WRITE;
        ram_addr  <= mem_ctrl[2] ? pc_in : ar_in;
        ram_wdata <= mem_ctrl[0] ? dr_in : '0;
        ram_we    <= mem_ctrl[0];
        ram_req   <= 1'b1;
        busy      <= 1'b1;
        tcnt      <= '0;
      end

      if (state_q == REQ && !(ack_ok || tmo)) begin
        tcnt <= tcnt + CNT_W'(1);
      end

      if (ack_ok || tmo) begin
        ram_req <= 1'b0;
        ram_we  <= 1'b0;
        busy    <= 1'b0;
        case (cmd_q)
          CMD_FETCH: begin
            ir_data <= cap_data;
            mbru    <= cap_data[5:0];
          end
          CMD_READ: dr_out <= cap_data;
          default: ;
        endcase
      end

      if (tmo)     err_timeout <= 1'b1;
      if (illegal) err_illegal <= 1'b1;
      if (overrun) err_overrun <= 1'b1;
    end
  end

endmodule
